dequantization: RTL and testbench
=================================

DEQUANTIZATION -- requirements
Module: dequantization

Interface
REQ-001 The clock SHALL be clk, 1 bit, input; all state is updated on its rising edge.
REQ-002 reset SHALL be input, 1 bit, asynchronous and active-high, clearing all state immediately.
REQ-003 in SHALL be a 64-bit input holding 8 signed 8-bit quantized coefficients: lane 0 at [63:56], lane 7 at [7:0].
REQ-004 in_valid (input, 1 bit) SHALL mark in as valid; in_ready (output, 1 bit) SHALL mark that the block can accept a beat.
REQ-005 sof (input, 1 bit) SHALL be sampled with an accepted beat and mark that beat as column 0 of a new 8x8 block.
REQ-006 out SHALL be an 80-bit output holding 8 signed 10-bit dequantized coefficients: lane 0 at [79:70], lane 7 at [9:0].
REQ-007 out_valid (output, 1 bit) SHALL mark out as valid; out_ready (input, 1 bit) SHALL mark that the consumer takes it.
REQ-008 out_last (output, 1 bit) SHALL be high with a beat that is column 7 of a block.
REQ-009 out_sat (output, 1 bit) SHALL be high when any lane of the current output beat was saturated.
REQ-010 tbl_we (input, 1 bit), tbl_addr (input, 6 bits) and tbl_data (input, 8 bits, unsigned) SHALL form the step-table write port.

Function
REQ-011 A beat SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-012 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-013 The block SHALL hold a 64-entry x 8-bit unsigned step table, row-major: address = row*8 + column.
REQ-014 A write SHALL occur on an edge with tbl_we=1 and SHALL take effect from the next edge.
REQ-015 A beat accepted on the same edge as a table write SHALL use the pre-write table contents.
REQ-016 An internal 3-bit column counter col SHALL select the table column for each accepted beat.
REQ-017 When an accepted beat has sof=1, it SHALL use column 0 and col SHALL become 1.
REQ-018 Otherwise an accepted beat SHALL use col, and col SHALL then increment, wrapping from 7 to 0.
REQ-019 col SHALL change only on accepted beats.
REQ-020 For lane i, the product SHALL be the signed 8-bit coefficient times the zero-extended table entry at row i, column = beat column; the product is a full 17-bit signed value.
REQ-021 Each product SHALL be saturated to the signed 10-bit range: above 511 gives 511; below -512 gives -512.
REQ-022 No rounding SHALL be applied; a table entry of 0 SHALL give an output of 0.
REQ-023 Latency SHALL be 1 cycle: out, out_last and out_sat SHALL be registered on the accepting edge, and out_valid SHALL be 1 from the following cycle.
REQ-024 out_last SHALL be 1 exactly when the beat used column 7.
REQ-025 out_valid SHALL clear on an edge with out_ready=1 and no new acceptance.
REQ-026 On an edge with both a new acceptance and out_ready=1, the new beat SHALL replace the old one and out_valid SHALL stay 1; no beat is lost or duplicated.
REQ-027 While out_valid=1 and out_ready=0, out, out_last and out_sat SHALL hold stable and in_ready SHALL be 0.

Reset
REQ-028 When reset is asserted, out_valid, out_last, out_sat and out SHALL be 0, and col SHALL be 0.
REQ-029 When reset is asserted, every table entry SHALL be 1, so that default operation is plain sign extension.
REQ-030 Reset asserted in the middle of a block SHALL discard the pending output beat; the first beat after reset SHALL use column 0 regardless of sof.
REQ-031 in_ready SHALL be 1 in the first cycle after reset is released.

Verification
REQ-032 Default table, lane 0 = 8'hFB and lane 7 = 8'h7F, sof=1 -> next cycle: out_valid=1, lane 0 = 10'h3FB, lane 7 = 10'h07F, out_sat=0, out_last=0.
REQ-033 Write tbl_addr 0 with 16 and tbl_addr 63 with 2; then 8 beats with all lanes = 8'h05, sof=1 on beat 1 -> beat 1 lane 0 = 10'h050; beat 8 lane 7 = 10'h00A, out_last=1; every other lane/beat = 10'h005.
REQ-034 tbl_addr 0 = 100; lane 0 = 8'h7F -> 10'h1FF with out_sat=1; lane 0 = 8'h80 -> 10'h200 with out_sat=1; lane 0 = 8'h05 -> 10'h1F4 with out_sat=0.
REQ-035 Hold out_ready=0 for 5 cycles with in_valid=1 -> one beat is accepted, in_ready=0, and out is stable; then out_ready=1 with continuous in_valid -> one beat per cycle, order preserved.
REQ-036 Apply 9 beats with sof only on beat 1 -> out_last=1 on beat 8 only, and beat 9 uses column 0.
REQ-037 Assert reset after 3 beats -> outputs are 0 and the table entry at address 0 is back to 1; the next beat uses column 0.
REQ-038 A table write to address 0 on the same edge as an accepted beat -> that beat uses the old entry and the following beat uses the new entry.

Source files
------------

// File: rtl/dequantization.sv
// 8-lane dequantizer: multiplies signed 8-bit coefficients by an unsigned per-position
// step table entry and saturates to signed 10 bits, with a one-deep registered output stage.
module dequantization (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sof,
    output logic [79:0] out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        out_sat,
    input  logic        tbl_we,
    input  logic [5:0]  tbl_addr,
    input  logic [7:0]  tbl_data
);

    logic [7:0]  r_tbl [64];
    logic [2:0]  r_col;
    logic [79:0] r_out;
    logic        r_out_valid;
    logic        r_out_last;
    logic        r_out_sat;

    logic        w_accept;
    logic [2:0]  w_col;
    logic [79:0] w_out;
    logic [7:0]  w_sat;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    // sof forces column 0 for the current beat regardless of the running counter.
    assign w_col    = sof ? 3'd0 : r_col;

    // NOTE: the step table is register-based because reset must load every entry with 1;
    // a RAM macro could not be initialised asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tbl <= '{default: 8'd1};
        end else if (tbl_we) begin
            r_tbl[tbl_addr] <= tbl_data;
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_lane
        logic signed [7:0]  w_coef;
        logic signed [8:0]  w_step;
        logic signed [16:0] w_prod;
        logic        [5:0]  w_idx;

        assign w_idx  = {3'(g), w_col};
        assign w_coef = in[63-8*g -: 8];
        assign w_step = {1'b0, r_tbl[w_idx]};
        assign w_prod = 17'(w_coef) * 17'(w_step);

        always_comb begin
            w_sat[g]              = 1'b0;
            w_out[79-10*g -: 10]  = w_prod[9:0];
            if (w_prod > 17'sd511) begin
                w_sat[g]             = 1'b1;
                w_out[79-10*g -: 10] = 10'h1FF;
            end else if (w_prod < -17'sd512) begin
                w_sat[g]             = 1'b1;
                w_out[79-10*g -: 10] = 10'h200;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col       <= 3'd0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_sat   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_col       <= w_col + 3'd1;
                r_out       <= w_out;
                r_out_last  <= (w_col == 3'd7);
                r_out_sat   <= |w_sat;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_dequantization.sv
// Scoreboard bench for dequantization: a driver predicts each accepted beat from an
// arithmetic reference model and a monitor compares whatever the DUT presents.
module tb_dequantization;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in;
    logic        in_valid;
    logic        in_ready;
    logic        sof;
    logic [79:0] out;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        out_sat;
    logic        tbl_we;
    logic [5:0]  tbl_addr;
    logic [7:0]  tbl_data;

    dequantization dut (
        .clk(clk), .reset(reset),
        .in(in), .in_valid(in_valid), .in_ready(in_ready), .sof(sof),
        .out(out), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .out_sat(out_sat),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [79:0] data;
        logic        last;
        logic        sat;
    } beat_t;

    beat_t sb[$];
    int    m_tbl[64];
    int    m_col;
    bit    m_valid;
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer multiply and clamp per lane.
    function automatic beat_t model_beat(input logic [63:0] d, input int c);
        beat_t b;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] cv;
            int v;
            cv = d[63-8*i -: 8];
            v  = int'($signed(cv)) * m_tbl[i*8+c];
            if (v > 511) begin
                v = 511;
                b.sat = 1'b1;
            end else if (v < -512) begin
                v = -512;
                b.sat = 1'b1;
            end
            b.data[79-10*i -: 10] = v[9:0];
        end
        b.last = (c == 7);
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_tbl[i] = 1;
        m_col   = 0;
        m_valid = 1'b0;
        sb.delete();
    endtask

    // One clock: check handshake outputs mid-cycle, then advance the model on the edge.
    task automatic cycle();
        bit acc;
        int c;
        @(negedge clk);
        check("in_ready", in_ready, !m_valid || out_ready);
        check("out_valid", out_valid, m_valid);
        acc = in_valid && (!m_valid || out_ready);
        @(posedge clk);
        if (acc) begin
            c = sof ? 0 : m_col;
            sb.push_back(model_beat(in, c));
            m_col = (c + 1) % 8;
        end
        if (tbl_we) m_tbl[tbl_addr] = int'(tbl_data);
        if (acc) m_valid = 1'b1;
        else if (out_ready) m_valid = 1'b0;
        #1;
    endtask

    task automatic beat(input logic [63:0] d, input bit s);
        in = d; sof = s; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0; sof = 1'b0;
    endtask

    task automatic tbl_write(input logic [5:0] a, input logic [7:0] v);
        tbl_we = 1'b1; tbl_addr = a; tbl_data = v;
        cycle();
        tbl_we = 1'b0;
    endtask

    // Monitor: compares the head of the scoreboard whenever a beat is presented; a stalled
    // beat is compared every cycle, which also checks that it holds stable.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && out_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %h expected no beat at %0t", out, $time);
                end else begin
                    check("out", out, sb[0].data);
                    check("out_last", out_last, sb[0].last);
                    check("out_sat", out_sat, sb[0].sat);
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        reset = 1'b1; in = '0; in_valid = 1'b0; sof = 1'b0; out_ready = 1'b1;
        tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0;
        model_reset();
        #2;
        check("rst_out", out, '0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_sat", out_sat, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Default table is plain sign extension.
        beat({8'hFB, 48'h0, 8'h7F}, 1'b1);
        cycle();

        // Corner table entries scale lane 0 column 0 and lane 7 column 7.
        tbl_write(6'd0, 8'd16);
        tbl_write(6'd63, 8'd2);
        for (int b = 0; b < 8; b++) beat({8{8'h05}}, b == 0);
        cycle();

        // Saturation at both extremes, and a large but in-range product.
        tbl_write(6'd0, 8'd100);
        beat({8'h7F, 56'h0}, 1'b1);
        beat({8'h80, 56'h0}, 1'b1);
        beat({8'h05, 56'h0}, 1'b1);
        cycle();

        // Back-pressure: one beat captured, then held; then full-rate streaming.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in = {$urandom, $urandom};
            sof = (k == 0);
            cycle();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in = {$urandom, $urandom};
            sof = 1'b0;
            cycle();
        end
        in_valid = 1'b0;
        cycle();

        // Nine beats: column wraps back to 0 on the ninth.
        for (int b = 0; b < 9; b++) beat({$urandom, $urandom}, b == 0);
        cycle();

        // Write on the same edge as an accepted beat: old entry first, new entry next.
        in = {8'h03, 56'h0}; sof = 1'b1; in_valid = 1'b1;
        tbl_we = 1'b1; tbl_addr = 6'd0; tbl_data = 8'd50;
        cycle();
        tbl_we = 1'b0;
        beat({8'h03, 56'h0}, 1'b1);
        cycle();

        // Reset mid-block discards the pending beat and restores the table.
        for (int b = 0; b < 3; b++) beat({$urandom, $urandom}, b == 0);
        reset = 1'b1;
        model_reset();
        #2;
        check("mid_rst_out", out, '0);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_out_last", out_last, 1'b0);
        check("mid_rst_out_sat", out_sat, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        beat({8'h7F, 48'h0, 8'h81}, 1'b0);
        cycle();

        // Randomised traffic with table rewrites and back-pressure.
        for (int k = 0; k < 3000; k++) begin
            in        = {$urandom, $urandom};
            in_valid  = ($urandom_range(0, 3) != 0);
            sof       = ($urandom_range(0, 11) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tbl_we    = ($urandom_range(0, 7) == 0);
            tbl_addr  = 6'($urandom_range(0, 63));
            tbl_data  = 8'($urandom);
            cycle();
        end

        in_valid = 1'b0; tbl_we = 1'b0; out_ready = 1'b1;
        repeat (3) cycle();
        check("sb_drained", 80'(sb.size()), 80'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
